// File: rtl/ram_bank.sv
//------------------------------------------------------------------------------
// Module   : ram_bank
// Purpose  : Single-port word RAM with byte enables and a fixed number of
//            wait cycles per access. Request handshake is req -> ack, with
//            busy covering the whole access. Out-of-range accesses are flagged
//            and have no effect on memory.
// Options  : Define RAM_BANK_PARITY_EN to add one even-parity bit per byte,
//            a par_err flag on reads and the test-only pinj input.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 128,
  parameter int WAIT   = 1
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_W-1:0]     dina,
`ifdef RAM_BANK_PARITY_EN
  input  logic                  pinj,
`endif
  output logic [DATA_W-1:0]     douta,
  output logic                  ack,
  output logic                  busy,
  output logic                  oor_err,
  output logic                  par_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic              r_we;
  logic [NB-1:0]     r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_dout;
  logic              r_ack;
  logic              r_oor;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_go;
  logic              w_acc_we;
  logic [NB-1:0]     w_acc_be;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_din;
  logic              w_oor;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_mem_wr;

  // Access operands: with no wait cycles the access happens on the accept
  // edge itself, so the live inputs are used instead of the latched copy.
  always_comb begin
    w_go       = ((r_state == ST_IDLE) && req && (WAIT == 0)) ||
                 ((r_state == ST_WAIT) && (r_cnt == 3'd0));
    w_acc_we   = (r_state == ST_IDLE) ? we    : r_we;
    w_acc_be   = (r_state == ST_IDLE) ? be    : r_be;
    w_acc_addr = (r_state == ST_IDLE) ? addra : r_addr;
    w_acc_din  = (r_state == ST_IDLE) ? dina  : r_din;
    w_oor      = ({1'b0, w_acc_addr} >= DEPTH_EXT);
    w_idx      = w_acc_addr[IDX_W-1:0];
    w_rd_word  = w_oor ? '0 : r_mem[w_idx];
    w_mem_wr   = w_go && w_acc_we && !w_oor && rsta_n;
  end

`ifdef RAM_BANK_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic          r_par_err;
  logic          w_par_bad;

  // Recompute parity of the addressed word and compare with stored bits.
  always_comb begin
    w_par_bad = 1'b0;
    if (!w_oor) begin
      for (int b = 0; b < NB; b++) begin
        if ((^r_mem[w_idx][8*b +: 8]) != r_par[w_idx][b]) begin
          w_par_bad = 1'b1;
        end
      end
    end
  end

  // Parity bits follow their byte; pinj corrupts them for fault testing.
  always_ff @(posedge clka) begin
    if (w_mem_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (w_acc_be[b]) begin
          r_par[w_idx][b] <= (^w_acc_din[8*b +: 8]) ^ pinj;
        end
      end
    end
  end

  // Parity error flag is only meaningful during the ack cycle of a read.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_go && !w_acc_we && w_par_bad;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  // Memory array: no reset so contents survive rsta_n.
  always_ff @(posedge clka) begin
    if (w_mem_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (w_acc_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_acc_din[8*b +: 8];
        end
      end
    end
  end

  // Control FSM, request latch and response registers.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_ack   <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_oor <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we   <= we;
            r_be   <= be;
            r_addr <= addra;
            r_din  <= dina;
            if (WAIT == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= 3'(WAIT - 1);
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_go) begin
        r_ack <= 1'b1;
        r_oor <= w_oor;
        if (!w_acc_we) begin
          r_dout <= w_rd_word;
        end
      end
    end
  end

  assign douta   = r_dout;
  assign ack     = r_ack;
  assign oor_err = r_oor;
  assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 The module SHALL have these parameters, one per line (name, default, meaning):
- DATA_W, 32: data width in bits, a multiple of 8.
- ADDR_W, 20: address width in bits.
- DEPTH, 128: number of words, at most 2^ADDR_W.
- WAIT, 1: wait cycles inserted before each access, 0..7.
REQ-002 The module SHALL have these ports, one per line (name, direction, width, meaning):
- clka  in  1  clock; all state changes on the rising edge.
- rsta_n  in  1  reset, asynchronous, active-low.
- req  in  1  access request.
- we  in  1  1 = write, 0 = read; sampled with req.
- be  in  DATA_W/8  byte enables for writes.
- addra  in  ADDR_W  word address.
- dina  in  DATA_W  write data.
- douta  out  DATA_W  read data.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  request in progress.
- oor_err  out  1  out-of-range flag; valid with ack.
- par_err  out  1  parity error flag; valid with ack.

Function
REQ-003 The module SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-004 In IDLE, a rising edge with req=1 SHALL latch we, be, addra and dina, and set busy=1.
- Next state: WAIT if WAIT>0, else RESP.
REQ-005 WAIT SHALL hold a 3-bit counter loaded with WAIT-1 and decrement it once per cycle.
- At counter 0 the FSM SHALL move to RESP.
REQ-006 The memory access SHALL occur on the edge entering RESP.
- ack=1 SHALL be asserted for exactly one cycle while in RESP.
- Net latency: req sampled at edge t0 gives ack high in cycle t0+WAIT+1.
REQ-007 RESP SHALL always return to IDLE on the next edge.
- busy SHALL be 1 from the accept edge through the RESP cycle inclusive.
- req SHALL be ignored whenever busy=1; no request queuing.
REQ-008 A write SHALL update only the bytes whose be bit is 1.
- be=0 SHALL complete normally with ack and change no memory.
REQ-009 On a write, douta SHALL retain its previous value.
- douta SHALL never be driven to high impedance.
REQ-010 A read SHALL load douta with the full word; douta SHALL hold that value until the next read completes.
REQ-011 An access with latched addra >= DEPTH SHALL set oor_err=1 during the RESP cycle.
- Such a write SHALL be suppressed.
- Such a read SHALL return all-zero douta.
REQ-012 oor_err and par_err SHALL be 0 in every cycle in which ack=0.
REQ-013 Address comparison SHALL use all ADDR_W bits, with no truncation or aliasing.

Reset
REQ-014 rsta_n=0 SHALL immediately force the following, regardless of clka:
- FSM to IDLE and counter to 0.
- ack=0, busy=0, oor_err=0, par_err=0, douta=0.
REQ-015 Reset mid-operation SHALL abandon the pending access.
- A latched write SHALL NOT reach memory.
- No ack SHALL follow reset release.
REQ-016 Memory contents SHALL NOT be cleared by reset.
REQ-017 The first request SHALL be accepted on the first rising edge with rsta_n=1.

Configuration
REQ-018 With macro RAM_BANK_PARITY_EN defined, the module SHALL store one even-parity bit per byte.
- Each parity bit SHALL be updated only when its byte is written.
- On a read, par_err SHALL be 1 in RESP if any stored parity bit mismatches its byte.
- Out-of-range reads SHALL report par_err=0.
- A test-only input pinj (1 bit) SHALL invert the stored parity on writes.
REQ-019 Without RAM_BANK_PARITY_EN, the module SHALL have no parity storage and no pinj port, and par_err SHALL be constant 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- WAIT=1: write 0xDEADBEEF to addr 5 with be=0xF, then read addr 5 -> ack in cycle t0+2 each time; read douta=0xDEADBEEF; oor_err=0.
- Addr 5 holds 0xDEADBEEF; write 0x11223344 with be=0x5, then read -> douta=0xDE22BE44.
- Read addr 200 (DEPTH=128) -> douta=0x00000000, oor_err=1 for one cycle; write to addr 200 leaves addr 200 mod 128 = 72 unchanged.
- WAIT=3: req held high continuously -> ack every 5 cycles; busy low exactly one cycle between accesses.
- Write to addr 9 in progress (WAIT=3); pulse rsta_n low in the second WAIT cycle -> no ack after release; addr 9 keeps its old data.
- RAM_BANK_PARITY_EN defined: write addr 3 with pinj=1, then read addr 3 -> par_err=1 with ack; a clean rewrite and read -> par_err=0.
